load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit for the pipelined RV32I core. It consumes the decoder's `MemSize`/`MemWrite` control and the ALU address, and drives a single-outstanding req/ack data bus. It generates byte enables and lane-replicated store data, and returns aligned, sign- or zero-extended load data. The unit holds the pipeline stalled via `Stall` until the bus transaction completes.

## Interface
Parameters:
- none; bus width is 32 and the address is 32 bits (fixed, RV32I).

Ports:
- `clk` in 1: core clock.
- `rst` in 1: reset; synchronous and active-high.
- `MemSize` in 2: 00 = no access, 01 = byte, 10 = half, 11 = word.
- `MemWrite` in 1: 1 = store, 0 = load; valid only when `MemSize != 0`.
- `LoadUnsigned` in 1: funct3[2]; 1 = zero-extend (LBU/LHU).
- `Addr` in 32: byte address from the ALU.
- `WriteData` in 32: store data, right-justified.
- `ReadData` out 32: extended load result.
- `Stall` out 1: hold the pipeline (combinational).
- `Misaligned` out 1: misaligned-access pulse; tied 0 when the configuration macro is absent.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32, `bus_be` out 4, `bus_wdata` out 32: bus request side, all registered.
- `bus_ack` in 1, `bus_rdata` in 32: bus response side.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - When `MemSize != 0`, register the bus fields and go to REQ.
  - `bus_addr = {Addr[31:2], 2'b00}` and `bus_we = MemWrite`.
- REQ:
  - `bus_req = 1`; all bus fields are held stable.
  - On `bus_ack`, capture `bus_rdata` into the load path (loads only), clear `bus_req`, and go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE. The pipeline advances at the end of DONE.
- `Stall = (IDLE & MemSize != 0) | REQ`. `Stall` is 0 in DONE.
- Byte enables and store data:
  - Byte: `bus_be = 4'b0001 << Addr[1:0]`; `bus_wdata = {4{WriteData[7:0]}}`.
  - Half: `bus_be = 4'b0011 << {Addr[1],1'b0}`; `bus_wdata = {2{WriteData[15:0]}}`.
  - Word: `bus_be = 4'b1111`; `bus_wdata = WriteData`.
  - Loads use the same `bus_be` encoding.
- Load extraction:
  - Byte lane is selected by `Addr[1:0]`; half lane by `Addr[1]`.
  - Sign-extend unless `LoadUnsigned`. Word loads pass through unchanged.
  - `ReadData` updates only when a load completes and holds its value otherwise.
- Misaligned access: a half access with `Addr[0]=1`, or a word access with `Addr[1:0]!=0`; see Configuration.
- `bus_ack` is ignored in IDLE and DONE.
- Inputs are guaranteed stable while `Stall = 1`.

## Timing
- Reset values: state = IDLE, `bus_req = 0`, `bus_we = 0`, `bus_addr = 0`, `bus_be = 0`, `bus_wdata = 0`, `ReadData = 0`, `Misaligned = 0`.
- Latency: the request is seen in cycle N and `bus_req` rises in N+1.
  - With ack in N+1, DONE is N+2 and `ReadData` is valid in N+2.
  - Minimum access time is 3 cycles. Each additional wait cycle adds one cycle.
- Back-to-back accesses: the next access is evaluated in the IDLE cycle right after DONE.
- Reset in REQ: state returns to IDLE and `bus_req = 0` on the next cycle. The abandoned transaction is not completed and `ReadData` is cleared.
- A non-access (`MemSize = 0`) in IDLE produces no stall and no bus activity.

## Configuration
- Macro `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - A misaligned access issues no bus request.
  - FSM goes IDLE→DONE directly; `Misaligned = 1` for the DONE cycle only.
  - `Stall` is high for the IDLE cycle only; `ReadData` is unchanged.
- Undefined:
  - `Misaligned` is tied 0.
  - A misaligned half uses the lane from `Addr[1]`; a misaligned word ignores `Addr[1:0]`. Both proceed as normal accesses.

## Structure
- Shared package `rv32i_pkg`:
  - `MemSize` encodings `MEM_NONE`, `MEM_BYTE`, `MEM_HALF`, `MEM_WORD`.
  - LSU state enum `lsu_state_t`.
- Sub-module `load_aligner`: combinational lane select plus sign/zero extension (`bus_rdata`, `Addr[1:0]`, `MemSize`, `LoadUnsigned` → 32-bit result). It is instantiated once.

## Test plan
- LB at `Addr = 0x103`, `bus_rdata = 0x80FF_1234`, ack in first REQ cycle → `bus_be = 4'b1000`, `bus_addr = 0x100`, `ReadData = 0xFFFF_FF80` in cycle N+2. `Stall` is high in N and N+1 and low in N+2.
- LHU at `Addr = 0x22`, `bus_rdata = 0xBEEF_0000` → `bus_be = 4'b1100`, `ReadData = 0x0000_BEEF`.
- SB at `Addr = 0x41`, `WriteData = 0x1234_56AB`, ack after 3 wait cycles → `bus_wdata = 0xABAB_ABAB`, `bus_be = 4'b0010`, `bus_we = 1`, fields stable across the waits. `Stall` stays high until ack and drops in DONE.
- SW then LW back-to-back to `0x200` → two separate requests, with `bus_req` low for exactly IDLE+DONE between them. The LW returns the bus data unchanged.
- Assert `rst` while in REQ with no ack → next cycle `bus_req = 0`, `Stall = 0`, `ReadData = 0`.
- LW at `Addr = 0x2`:
  - With `LSU_MISALIGN_TRAP_EN`: no `bus_req`, a one-cycle `Misaligned` pulse, `ReadData` unchanged.
  - Without it: a word access to `0x0` with `bus_be = 4'b1111`.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: MemSize encodings, LSU state type and the
// byte-enable / store-lane helpers used by the load/store unit.
package rv32i_pkg;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  function automatic logic [3:0] lsu_byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: lsu_byte_en = 4'b0001 << addr_lo;
      MEM_HALF: lsu_byte_en = 4'b0011 << {addr_lo[1], 1'b0};
      MEM_WORD: lsu_byte_en = 4'b1111;
      default:  lsu_byte_en = 4'b0000;
    endcase
  endfunction

  // Stores replicate the right-justified data across every lane it may land in.
  function automatic logic [31:0] lsu_store_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      MEM_BYTE: lsu_store_data = {4{data[7:0]}};
      MEM_HALF: lsu_store_data = {2{data[15:0]}};
      default:  lsu_store_data = data;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    lsu_misaligned = ((size == MEM_HALF) && addr_lo[0]) ||
                     ((size == MEM_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load lane select with sign/zero extension of bus read data.
module load_aligner
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (addr_lo_i)
      2'd0: byte_lane = rdata_i[7:0];
      2'd1: byte_lane = rdata_i[15:8];
      2'd2: byte_lane = rdata_i[23:16];
      2'd3: byte_lane = rdata_i[31:24];
      default: byte_lane = 8'h00;
    endcase
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    result_o = rdata_i;
    case (size_i)
      MEM_BYTE: result_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
      MEM_HALF: result_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
      default:  result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit driving a single-outstanding req/ack bus.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned accesses into a
// one-cycle Misaligned pulse with no bus request.
module load_store_unit
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MemSize,
  input  logic        MemWrite,
  input  logic        LoadUnsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Misaligned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // Bus handshake: bus_req rises with all fields valid and holds them stable
  // until the cycle bus_ack is sampled high; bus_ack outside REQ is ignored.
  lsu_state_t  state_q, state_d;
  logic        access, trap;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q, read_data_q, load_result;
  logic [3:0]  bus_be_q;

  assign access = (MemSize != MEM_NONE);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_q;
  assign trap = access && lsu_misaligned(MemSize, Addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) misaligned_q <= 1'b0;
    else     misaligned_q <= (state_q == LSU_IDLE) && trap;
  end
  assign Misaligned = misaligned_q;
`else
  assign trap       = 1'b0;
  assign Misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= LSU_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (access) state_d = trap ? LSU_DONE : LSU_REQ;
      LSU_REQ:  if (bus_ack) state_d = LSU_DONE;
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    Stall = ((state_q == LSU_IDLE) && access) || (state_q == LSU_REQ);
  end

  // Addr, MemSize and LoadUnsigned are held by the stalled pipeline, so the
  // aligner can work on the live bus data in the ack cycle.
  load_aligner u_load_aligner (
    .rdata_i    (bus_rdata),
    .addr_lo_i  (Addr[1:0]),
    .size_i     (MemSize),
    .unsigned_i (LoadUnsigned),
    .result_o   (load_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      read_data_q <= 32'h0;
    end else begin
      if ((state_q == LSU_IDLE) && access && !trap) begin
        bus_req_q   <= 1'b1;
        bus_we_q    <= MemWrite;
        bus_addr_q  <= {Addr[31:2], 2'b00};
        bus_be_q    <= lsu_byte_en(MemSize, Addr[1:0]);
        bus_wdata_q <= lsu_store_data(MemSize, WriteData);
      end else if ((state_q == LSU_REQ) && bus_ack) begin
        bus_req_q <= 1'b0;
      end
      if ((state_q == LSU_REQ) && bus_ack && !bus_we_q) read_data_q <= load_result;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign ReadData  = read_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit; honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  MemSize;
  logic        MemWrite, LoadUnsigned;
  logic [31:0] Addr, WriteData, ReadData;
  logic        Stall, Misaligned;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  load_store_unit dut (
    .clk(clk), .rst(rst), .MemSize(MemSize), .MemWrite(MemWrite),
    .LoadUnsigned(LoadUnsigned), .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .Misaligned(Misaligned),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [1:0] a,
                                           input logic uns, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> (8 * a));
    h = a[1] ? d[31:16] : d[15:0];
    if (size == MEM_BYTE) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (size == MEM_HALF) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return d;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] a);
    if (size == MEM_BYTE)
      case (a) 2'd0: return 4'b0001; 2'd1: return 4'b0010; 2'd2: return 4'b0100; default: return 4'b1000; endcase
    if (size == MEM_HALF) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == MEM_BYTE) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (size == MEM_HALF) return {d[15:0], d[15:0]};
    return d;
  endfunction

  // driver: called at a negedge in IDLE (or in DONE when from_done); returns at the DONE negedge
  task automatic do_access(input logic [1:0] size, input logic we, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int waits, input bit from_done);
    MemSize = size; MemWrite = we; LoadUnsigned = uns; Addr = a; WriteData = wd;
    if (from_done) begin
      @(posedge clk); @(negedge clk);
      check("gap_req_low", bus_req, 0);
    end
    #1;
    check("idle_stall", Stall, 1);
    if (!we) exp_q.push_back(ref_load(size, a[1:0], uns, rd));
    @(posedge clk); @(negedge clk);
    for (int w = 0; w <= waits; w++) begin
      check("req_high", bus_req, 1);
      check("req_we", bus_we, we);
      check("req_addr", bus_addr, {a[31:2], 2'b00});
      check("req_be", bus_be, ref_be(size, a[1:0]));
      if (we) check("req_wdata", bus_wdata, ref_wdata(size, wd));
      check("req_stall", Stall, 1);
      bus_ack   = (w == waits);
      bus_rdata = (w == waits) ? rd : $urandom;
      @(posedge clk); @(negedge clk);
    end
    bus_ack = 1'b0;
    check("done_req_low", bus_req, 0);
    check("done_stall", Stall, 0);
    check("done_misaligned", Misaligned, 0);
    if (!we) begin
      check("sb_size", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        last_rd = exp_q.pop_front();
        check("load_data", ReadData, last_rd);
      end
    end else begin
      check("store_rd_hold", ReadData, last_rd);
    end
  endtask

  task automatic idle_cycle();
    MemSize = MEM_NONE; MemWrite = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_nostall", Stall, 0);
    check("idle_noreq", bus_req, 0);
  endtask

  initial begin
    rst = 1'b1; MemSize = MEM_NONE; MemWrite = 0; LoadUnsigned = 0;
    Addr = 0; WriteData = 0; bus_ack = 0; bus_rdata = 0; last_rd = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", bus_be, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_rdata", ReadData, 0);
    check("rst_misaligned", Misaligned, 0);
    check("rst_stall", Stall, 0);
    rst = 1'b0;
    // stray ack in IDLE must be ignored
    bus_ack = 1'b1;
    idle_cycle();
    bus_ack = 1'b0;
    idle_cycle();

    do_access(MEM_BYTE, 0, 0, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);   // LB -> FFFFFF80
    idle_cycle();
    do_access(MEM_HALF, 0, 1, 32'h22, 32'h0, 32'hBEEF_0000, 0, 0);    // LHU -> 0000BEEF
    idle_cycle();
    do_access(MEM_BYTE, 1, 0, 32'h41, 32'h1234_56AB, 32'h0, 3, 0);    // SB with 3 waits
    idle_cycle();
    do_access(MEM_WORD, 1, 0, 32'h200, 32'hCAFE_F00D, 32'h0, 0, 0);   // SW
    do_access(MEM_WORD, 0, 0, 32'h200, 32'h0, 32'h1357_9BDF, 0, 1);   // LW back-to-back
    idle_cycle();

    for (int i = 0; i < 10; i++) begin
      logic [1:0]  sz;
      logic [1:0]  off;
      sz  = 2'($urandom_range(1, 3));
      off = (sz == MEM_BYTE) ? 2'($urandom_range(0, 3)) : (sz == MEM_HALF) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      do_access(sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {$urandom_range(0, 4095), off}, $urandom, $urandom, $urandom_range(0, 2), 0);
      if ($urandom_range(0, 1) == 1) idle_cycle();
      else idle_cycle();
    end

`ifdef LSU_MISALIGN_TRAP_EN
    MemSize = MEM_WORD; MemWrite = 0; LoadUnsigned = 0; Addr = 32'h2;
    #1;
    check("mis_idle_stall", Stall, 1);
    @(posedge clk); @(negedge clk);
    check("mis_no_req", bus_req, 0);
    check("mis_pulse", Misaligned, 1);
    check("mis_done_stall", Stall, 0);
    check("mis_rd_hold", ReadData, last_rd);
    MemSize = MEM_NONE;
    @(posedge clk); @(negedge clk);
    check("mis_pulse_end", Misaligned, 0);
    check("mis_no_req2", bus_req, 0);
`else
    do_access(MEM_WORD, 0, 0, 32'h2, 32'h0, 32'h8765_4321, 0, 0);     // misaligned LW as word @0
    idle_cycle();
`endif

    // reset while waiting in REQ
    MemSize = MEM_WORD; MemWrite = 0; Addr = 32'h300;
    @(posedge clk); @(negedge clk);
    check("rreq_req", bus_req, 1);
    rst = 1'b1; MemSize = MEM_NONE;
    @(posedge clk); @(negedge clk);
    check("rreq_req_low", bus_req, 0);
    check("rreq_stall", Stall, 0);
    check("rreq_rdata", ReadData, 0);
    rst = 1'b0; last_rd = 32'h0;
    idle_cycle();
    do_access(MEM_BYTE, 0, 1, 32'h12, 32'h0, 32'h00A5_0000, 1, 0);    // LBU after reset
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
